// File: rtl/mfp_eic_pkg.sv
// Shared constants and FSM encoding for the MIPSfpga+ EIC request sequencer.
package mfp_eic_pkg;

    localparam int unsigned MFP_EIC_MAX_CHANNELS = 63;
    localparam int unsigned VW                   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2
    } eic_state_t;

endpackage

// File: rtl/mfp_eic_select.sv
// Masked priority encoder: highest-index pending and enabled channel wins; idx is 0 when nothing is found.
module mfp_eic_select
    import mfp_eic_pkg::*;
#(
    parameter int unsigned CHANNELS = 32
) (
    input  logic [CHANNELS-1:0] pending,
    input  logic [CHANNELS-1:0] mask,
    output logic                found_c,
    output logic [VW-1:0]       idx_c
);

    logic [CHANNELS-1:0] req;

    assign req = pending & mask;

    // Ascending scan so the last (highest) hit overrides earlier ones.
    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (req[i]) begin
                found_c = 1'b1;
                idx_c   = VW'(i);
            end
        end
    end

endmodule

// File: rtl/mfp_eic_sequencer.sv
// EIC interrupt latch and request/acknowledge sequencer towards the core.
// Define MFP_EIC_SYNC_EN to add a 2-flop synchronizer on the irq inputs.
module mfp_eic_sequencer
    import mfp_eic_pkg::*;
#(
    parameter int unsigned CHANNELS = 32
) (
    input  logic                SI_ClkIn,
    input  logic                SI_Reset,
    input  logic [CHANNELS-1:0] irq,
    input  logic [CHANNELS-1:0] irq_mask,
    input  logic [CHANNELS-1:0] irq_sense,
    output logic [CHANNELS-1:0] irq_pending,
    output logic [VW-1:0]       EIC_RIPL,
    output logic [VW-1:0]       EIC_Vector,
    input  logic                EIC_IAck,
    output logic                eic_busy
);

    if (CHANNELS < 1 || CHANNELS > MFP_EIC_MAX_CHANNELS) begin : g_bad_channels
        $error("mfp_eic_sequencer: CHANNELS out of range");
    end

    logic [CHANNELS-1:0] irq_s;
    logic [CHANNELS-1:0] irq_prev;
    logic [CHANNELS-1:0] edge_lat;
    logic [CHANNELS-1:0] edge_set;
    logic [CHANNELS-1:0] edge_clr;

    eic_state_t          state;
    eic_state_t          state_d;
    logic [VW-1:0]       served;
    logic [VW-1:0]       served_d;
    logic [VW-1:0]       ripl_d;
    logic [VW-1:0]       vector_d;
    logic                found;
    logic [VW-1:0]       idx;

`ifdef MFP_EIC_SYNC_EN
    logic [CHANNELS-1:0] sync_q1;
    logic [CHANNELS-1:0] sync_q2;

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    assign irq_s = irq;
`endif

    assign edge_set    = irq_s & ~irq_prev & irq_sense;
    // Only an edge-sensed served channel loses its latch; level lines are owned by the source.
    assign edge_clr    = (state == ST_SERVE) ? ((CHANNELS'(1) << served) & irq_sense) : '0;
    assign irq_pending = (edge_lat & irq_sense) | (irq_s & ~irq_sense);

    // Set wins over a same-cycle clear so a fresh edge during SERVE is not lost.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            irq_prev <= irq_s;
            edge_lat <= '0;
        end else begin
            irq_prev <= irq_s;
            edge_lat <= (edge_lat & ~edge_clr) | edge_set;
        end
    end

    mfp_eic_select #(
        .CHANNELS (CHANNELS)
    ) u_select (
        .pending (irq_pending),
        .mask    (irq_mask),
        .found_c (found),
        .idx_c   (idx)
    );

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            state      <= ST_IDLE;
            served     <= '0;
            EIC_RIPL   <= '0;
            EIC_Vector <= '0;
            eic_busy   <= 1'b0;
        end else begin
            state      <= state_d;
            served     <= served_d;
            EIC_RIPL   <= ripl_d;
            EIC_Vector <= vector_d;
            eic_busy   <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d  = state;
        served_d = served;
        ripl_d   = EIC_RIPL;
        vector_d = EIC_Vector;
        unique case (state)
            ST_IDLE: begin
                if (found) begin
                    vector_d = idx;
                    ripl_d   = idx + VW'(1);
                    state_d  = ST_REQ;
                end else begin
                    vector_d = '0;
                    ripl_d   = '0;
                end
            end
            ST_REQ: begin
                // The ack refers to what the core saw this cycle, not to a new preemptor.
                if (EIC_IAck) begin
                    served_d = EIC_Vector;
                    ripl_d   = '0;
                    state_d  = ST_SERVE;
                end else if (found) begin
                    vector_d = idx;
                    ripl_d   = idx + VW'(1);
                end else begin
                    vector_d = '0;
                    ripl_d   = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_SERVE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                vector_d = '0;
                ripl_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mfp_eic_sequencer.sv
// Scoreboard bench for mfp_eic_sequencer: expectations are queued with a target cycle and checked by a monitor.
module tb_mfp_eic_sequencer;

    localparam int unsigned CH = 32;

    typedef struct {
        int    cyc;
        string nm;
        int    ripl;
        int    vec;
        int    pbit;
        bit    pval;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [CH-1:0] irq;
    logic [CH-1:0] mask;
    logic [CH-1:0] sense;
    logic [CH-1:0] pending;
    logic [5:0]    ripl;
    logic [5:0]    vector;
    logic          iack;
    logic          busy;

    int   cyc;
    int   errors;
    int   checks;
    exp_t sb[$];

    mfp_eic_sequencer #(
        .CHANNELS (CH)
    ) dut (
        .SI_ClkIn    (clk),
        .SI_Reset    (rst),
        .irq         (irq),
        .irq_mask    (mask),
        .irq_sense   (sense),
        .irq_pending (pending),
        .EIC_RIPL    (ripl),
        .EIC_Vector  (vector),
        .EIC_IAck    (iack),
        .eic_busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Queue an expectation for the state seen after n more rising edges (-1 = don't care).
    task automatic expect_at(input int n, input string nm, input int r, input int v, input int pb, input bit pv);
        exp_t e;
        e.cyc  = cyc + n;
        e.nm   = nm;
        e.ripl = r;
        e.vec  = v;
        e.pbit = pb;
        e.pval = pv;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input exp_t e);
        if (e.ripl >= 0) begin
            checks++;
            if (int'(ripl) != e.ripl) begin
                errors++;
                $display("FAIL %s: EIC_RIPL=%0d required %0d (cycle %0d)", e.nm, ripl, e.ripl, cyc);
            end
        end
        if (e.vec >= 0) begin
            checks++;
            if (int'(vector) != e.vec) begin
                errors++;
                $display("FAIL %s: EIC_Vector=%0d required %0d (cycle %0d)", e.nm, vector, e.vec, cyc);
            end
        end
        if (e.pbit >= 0) begin
            checks++;
            if (pending[e.pbit] != e.pval) begin
                errors++;
                $display("FAIL %s: irq_pending[%0d]=%0b required %0b (cycle %0d)", e.nm, e.pbit,
                         pending[e.pbit], e.pval, cyc);
            end
        end
    endtask

    // Monitor: pops every expectation whose cycle has come and compares it to the DUT.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                check_entry(sb[i]);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic ack_once();
        iack = 1'b1;
        step(1);
        iack = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        irq    = '0;
        irq[3] = 1'b1;
        mask   = '1;
        sense  = '1;
        iack   = 1'b0;
        step(3);
        rst = 1'b0;

        // A line already high through reset must not look like an edge.
        expect_at(0, "reset_state", 0, 0, 3, 1'b0);
        for (int k = 1; k <= 10; k++) expect_at(k, "reset_no_edge", 0, -1, 3, 1'b0);
        step(10);

        // Single edge channel, full request/ack/serve round trip.
        irq[5] = 1'b1;
        expect_at(1, "edge5_pending", 0, -1, 5, 1'b1);
        expect_at(2, "edge5_request", 6, 5, 5, 1'b1);
        step(2);
        expect_at(1, "edge5_ack_drop", 0, -1, 5, 1'b1);
        ack_once();
        irq[5] = 1'b0;
        expect_at(1, "edge5_cleared", 0, -1, 5, 1'b0);
        expect_at(2, "edge5_idle_a", 0, -1, -1, 1'b0);
        expect_at(3, "edge5_idle_b", 0, -1, -1, 1'b0);
        step(3);

        // Preemption of channel 2 by channel 9, then return to 2.
        irq[2] = 1'b1;
        expect_at(2, "ch2_request", 3, 2, -1, 1'b0);
        step(2);
        irq[9] = 1'b1;
        expect_at(1, "ch9_not_yet", 3, 2, 9, 1'b1);
        expect_at(2, "ch9_preempt", 10, 9, -1, 1'b0);
        step(2);
        expect_at(1, "ch9_ack_drop", 0, -1, -1, 1'b0);
        ack_once();
        expect_at(1, "ch9_cleared", 0, -1, 9, 1'b0);
        expect_at(2, "ch2_rerequest", 3, 2, 2, 1'b1);
        step(2);
        expect_at(1, "ch2_ack_drop", 0, -1, -1, 1'b0);
        ack_once();
        expect_at(1, "ch2_cleared", 0, -1, 2, 1'b0);
        expect_at(2, "ch2_idle", 0, 0, -1, 1'b0);
        step(2);
        irq[2] = 1'b0;
        irq[9] = 1'b0;

        // Level channel 7 survives the ack and re-requests until released.
        sense[7] = 1'b0;
        irq[7]   = 1'b1;
        expect_at(0, "lvl7_pending", -1, -1, 7, 1'b1);
        expect_at(1, "lvl7_request", 8, 7, -1, 1'b0);
        step(1);
        expect_at(1, "lvl7_ack_drop", 0, -1, 7, 1'b1);
        ack_once();
        expect_at(1, "lvl7_still_pending", 0, -1, 7, 1'b1);
        expect_at(2, "lvl7_rerequest", 8, 7, -1, 1'b0);
        step(2);
        irq[7] = 1'b0;
        expect_at(0, "lvl7_released", -1, -1, 7, 1'b0);
        expect_at(1, "lvl7_withdrawn", 0, 0, -1, 1'b0);
        step(1);
        sense[7] = 1'b1;
        step(1);

        // New edge on 4 in the very cycle SERVE clears 4: the set must win.
        irq[4] = 1'b1;
        expect_at(2, "ch4_request", 5, 4, -1, 1'b0);
        step(2);
        irq[4] = 1'b0;
        expect_at(1, "ch4_ack_drop", 0, -1, -1, 1'b0);
        ack_once();
        irq[4] = 1'b1;
        expect_at(1, "ch4_set_wins", 0, -1, 4, 1'b1);
        expect_at(2, "ch4_rerequest", 5, 4, -1, 1'b0);
        step(2);
        expect_at(1, "ch4_ack2_drop", 0, -1, -1, 1'b0);
        ack_once();
        expect_at(1, "ch4_cleared", 0, -1, 4, 1'b0);
        step(2);
        irq[4] = 1'b0;

        // Masked channel latches and shows pending but never requests until enabled.
        mask[6] = 1'b0;
        irq[6]  = 1'b1;
        expect_at(1, "mask6_pending", 0, -1, 6, 1'b1);
        expect_at(3, "mask6_no_req", 0, -1, 6, 1'b1);
        step(3);
        mask[6] = 1'b1;
        expect_at(1, "mask6_enabled", 7, 6, -1, 1'b0);
        step(1);

        // Reset in the middle of a request, with a concurrent ack that must be lost.
        rst  = 1'b1;
        iack = 1'b1;
        expect_at(1, "midrst_outputs", 0, 0, 6, 1'b0);
        step(1);
        rst  = 1'b0;
        iack = 1'b0;
        expect_at(2, "midrst_quiet", 0, 0, 6, 1'b0);
        step(2);
        irq[6] = 1'b0;

        for (int k = 0; k < 50 && sb.size() != 0; k++) step(1);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mfp_eic_sequencer.md
Name: mfp_eic_sequencer

Overview:
- Per-channel interrupt latch plus request/acknowledge sequencer for the MIPSfpga+ external interrupt controller (EIC).
- Captures edge- or level-sensed IRQ lines, masks them, and selects the highest-index pending channel through a masked priority encoder.
- Presents the selected channel to the core as a registered vector/RIPL pair, holds it until the core acknowledges, then clears the served edge latch.
- Sits between the EIC register block (which supplies mask/sense) and the core's EIC port.

Parameters:
- CHANNELS, 32, number of IRQ inputs; legal range 1..63. Channel i has priority i; higher index wins.
- VW, 6, vector/RIPL width; fixed at 6.

Ports:
- SI_ClkIn  input  1  system clock; all state on rising edge.
- SI_Reset  input  1  synchronous, active-high reset.
- irq  input  CHANNELS  raw interrupt request lines.
- irq_mask  input  CHANNELS  1 = channel enabled for selection; static config.
- irq_sense  input  CHANNELS  1 = rising-edge sensed, 0 = level sensed; static config.
- irq_pending  output  CHANNELS  effective pending vector (edge latch or level input), unmasked; status readback.
- EIC_RIPL  output  VW  requested level = selected index+1; 0 = no request.
- EIC_Vector  output  VW  selected channel index.
- EIC_IAck  input  1  one-cycle acknowledge from core; the currently presented vector is taken.
- eic_busy  output  1  high in REQ or SERVE.

Behaviour:
- Reset (SI_Reset=1 at an edge): edge latches = 0; EIC_RIPL = 0; EIC_Vector = 0; state = IDLE; irq_prev <= irq (tracks input, so a line already high at reset release creates no edge).
- Edge latch: set at clock k when irq[i] & ~irq_prev[i] & irq_sense[i]. Cleared only in SERVE, for the served index.
  - Set and clear of the same bit in one cycle: set wins.
- Level channel: pending = irq[i] directly. Never latched; never cleared by the sequencer.
- Mask gates selection only. Masked channels still latch, and still show in irq_pending.
- Select = priority encode (irq_pending & irq_mask), combinational → {found, idx}.
- FSM:
  - IDLE: if found, register EIC_Vector=idx and EIC_RIPL=idx+1, go REQ. Otherwise outputs stay 0.
  - REQ: each cycle without EIC_IAck, re-register the selection. A higher channel preempts. If found drops (level release, or mask cleared), RIPL=0 and Vector=0, go IDLE.
  - REQ with EIC_IAck: latch served=EIC_Vector (the value presented in that cycle, not the new selection); force RIPL=0; go SERVE.
  - SERVE (1 cycle): clear the edge latch for served if irq_sense[served]; go IDLE.
- EIC_IAck outside REQ is ignored.
- Latency: edge seen before clock k → pending after k → RIPL valid after k+1. Ack at clock a → RIPL=0 after a. The next request appears no earlier than after a+2.
- Mid-operation reset: immediate return to the reset values; any in-flight ack is lost.

Optional Feature:
- MFP_EIC_SYNC_EN defined: irq passes through a 2-flop synchronizer (reset to 0) before edge and level logic. Add 2 cycles to every latency above. irq_prev tracks the synchronized value.
- Not defined: irq is assumed synchronous to SI_ClkIn; no extra latency.

Decomposition:
- Package mfp_eic_pkg:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, SERVE=2'd2.
  - MFP_EIC_MAX_CHANNELS=63.
  - VW=6.
- Sub-module mfp_eic_select: generic masked priority encoder, CHANNELS → {found, 6-bit idx}, highest index wins, idx=0 when not found. Purely combinational; instantiated once.

Test Plan:
- Reset release with irq[3]=1, sense[3]=1 → no pending, EIC_RIPL=0 for 10 cycles.
- irq[5] edge, sense=1, mask=1 → irq_pending[5]=1 after 1 clock; RIPL=6, Vector=5 after 2. Pulse EIC_IAck → RIPL=0 next clock; pending[5]=0 after SERVE; RIPL stays 0.
- Channel 2 in REQ (RIPL=3), then irq[9] edge → RIPL=10, Vector=9. Ack → serve 9. Return to REQ with RIPL=3.
- Level channel 7 (sense=0) held high, acked → pending[7] stays 1; RIPL=8 reappears 2 clocks after ack. Drop irq[7] → RIPL=0 next clock.
- New edge on channel 4 in the same cycle SERVE clears 4 → pending[4] remains 1; RIPL=5 re-requested.
- mask[6]=0, irq[6] edge → pending[6]=1, RIPL=0. Set mask[6]=1 → RIPL=7 after 1 clock.
